// File: rtl/piso_pkg.sv
// Shared state encoding for the PISO serializer.
// Optional parity beat is enabled with macro PISO_PARITY_EN.
package piso_pkg;

`ifdef PISO_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  localparam bit HAS_PARITY = 1'b0;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/piso_sel_counter.sv
// Beat select counter: synchronous clear/enable, terminal count at N-1.
module piso_sel_counter #(
  parameter int select_lines = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  output logic [select_lines-1:0] s,
  output logic                    tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s <= '0;
    else if (clr) s <= '0;
    else if (en)  s <= s + 1'b1;
  end

  assign tc = &s;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity beat after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter  int select_lines = 2,
  localparam int N            = 2**select_lines
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            data_i,
  output logic [select_lines-1:0] s,
  output logic [N-1:0]            i,
  output logic                    o,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_last
);

  state_t state;
  logic   beat, tc, done, cnt_clr, cnt_en;

  assign beat = o_valid & o_ready;

`ifdef PISO_PARITY_EN
  assign done = (state == PARITY) & beat;
`else
  assign done = (state == SHIFT) & beat & tc;
`endif

  // s sits at 0 in IDLE and stays at N-1 through the parity beat
  assign cnt_clr = (state == IDLE) | done;
  assign cnt_en  = (state == SHIFT) & beat & ~tc;

  piso_sel_counter #(.select_lines(select_lines)) u_sel (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .s   (s),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          i       <= data_i;
          state   <= SHIFT;
          o_valid <= 1'b1;
        end
        SHIFT: if (beat && tc) begin
`ifdef PISO_PARITY_EN
          state   <= PARITY;
`else
          state   <= IDLE;
          o_valid <= 1'b0;
`endif
        end
`ifdef PISO_PARITY_EN
        PARITY: if (beat) begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
`endif
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);

  always_comb begin
    o      = 1'b0;
    o_last = 1'b0;
    case (state)
      SHIFT: begin
        o      = i[s];
        o_last = tc & ~HAS_PARITY;
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        o      = ^i;
        o_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
